// File: rtl/vram_port.sv
// vram_port: video-fetch responder that commits CPU screen writes to BRAM through a forwarding FIFO
module vram_port #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        ce_7mn,
    input  logic [14:0]                 vram_addr,
    output logic [7:0]                  vram_dout,
    input  logic [15:0]                 addr,
    input  logic [7:0]                  din,
    input  logic                        nMREQ,
    input  logic                        nWR,
    input  logic                        m128,
    input  logic [2:0]                  page_ram,
    output logic [14:0]                 ram_addr,
    output logic [7:0]                  ram_din,
    output logic                        ram_we,
    input  logic [7:0]                  ram_dout,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {DRAIN, VREAD, VCAPT} state_t;
    state_t r_state, w_next;
    logic [14:0] r_q_addr [FIFO_DEPTH];
    logic [7:0] r_q_data [FIFO_DEPTH];
    logic [LW-1:0] r_wp, r_rp, w_level;
    logic [AW-1:0] w_slot;
    logic [14:0] r_ram_addr, w_entry_addr;
    logic [7:0] r_ram_din, r_vram_dout, r_fwd_data, w_fwd_data;
    logic r_ram_we, r_fwd_hit, r_ovf, r_wr_act;
    logic w_wr_act, w_bank5, w_bank7, w_push, w_pop, w_full, w_accept, w_fwd_hit;
    assign w_wr_act = ~nMREQ & ~nWR;
    assign w_bank5 = (addr[15:14] == 2'b01) | ((addr[15:14] == 2'b11) & m128 & (page_ram == 3'd5));
    assign w_bank7 = (addr[15:14] == 2'b11) & m128 & (page_ram == 3'd7);
    assign w_entry_addr = {w_bank7, addr[13:0]};
    assign w_push = w_wr_act & ~r_wr_act & (w_bank5 | w_bank7);
    assign w_level = r_wp - r_rp;
    assign w_full = w_level == LW'(FIFO_DEPTH);
    assign w_accept = w_push & (~w_full | w_pop);
    always_comb begin
        w_next = (r_state == VREAD) ? VCAPT : ce_7mn ? VREAD : DRAIN;
        w_pop = (r_state == DRAIN) & ~ce_7mn & (w_level != '0);
    end
    // oldest-to-newest walk so the newest matching entry wins
    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_data = 8'h00;
        w_slot = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_slot = r_rp[AW-1:0] + AW'(i);
            if ((LW'(i) < w_level) && (r_q_addr[w_slot] == r_ram_addr)) begin
                w_fwd_hit = 1'b1;
                w_fwd_data = r_q_data[w_slot];
            end
        end
    end
    always_ff @(posedge clk_sys) begin
        if (w_accept) begin
            r_q_addr[r_wp[AW-1:0]] <= w_entry_addr;
            r_q_data[r_wp[AW-1:0]] <= din;
        end
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= DRAIN;
            r_wr_act <= 1'b0;
            r_wp <= '0;
            r_rp <= '0;
            r_ram_addr <= '0;
            r_ram_din <= '0;
            r_ram_we <= 1'b0;
            r_vram_dout <= '0;
            r_fwd_hit <= 1'b0;
            r_fwd_data <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_act <= w_wr_act;
            r_ram_we <= w_pop;
            if (w_accept) r_wp <= r_wp + LW'(1);
            if (w_push & ~w_accept) r_ovf <= 1'b1;
            if (w_pop) begin
                r_ram_addr <= r_q_addr[r_rp[AW-1:0]];
                r_ram_din <= r_q_data[r_rp[AW-1:0]];
                r_rp <= r_rp + LW'(1);
            end else if (w_next == VREAD) begin
                r_ram_addr <= vram_addr;
            end
            if (r_state == VREAD) begin
                r_fwd_hit <= w_fwd_hit;
                r_fwd_data <= w_fwd_data;
            end
            if (r_state == VCAPT) r_vram_dout <= r_fwd_hit ? r_fwd_data : ram_dout;
        end
    end
    assign vram_dout = r_vram_dout;
    assign ram_addr = r_ram_addr;
    assign ram_din = r_ram_din;
    assign ram_we = r_ram_we;
    assign fifo_level = w_level;
    assign ovf = r_ovf;
endmodule

// File: tb/tb_vram_port.sv
// tb_vram_port: directed and randomized checks of vram_port against a shadow screen-memory model
module tb_vram_port;
    logic clk_sys = 1'b0, reset = 1'b1, ce_7mn = 1'b0, nMREQ = 1'b1, nWR = 1'b1, m128 = 1'b0;
    logic [14:0] vram_addr = '0, ram_addr;
    logic [15:0] addr = '0;
    logic [7:0] din = '0, vram_dout, ram_din, ram_dout = '0;
    logic [2:0] page_ram = '0, fifo_level;
    logic ram_we, ovf;
    logic [7:0] bram [32768] = '{default: 8'h00};
    logic [7:0] ref_mem [32768] = '{default: 8'h00};
    int n_chk = 0, n_err = 0, wcnt = 0;
    bit spam = 1'b0;

    vram_port dut (
        .clk_sys(clk_sys), .reset(reset), .ce_7mn(ce_7mn), .vram_addr(vram_addr),
        .vram_dout(vram_dout), .addr(addr), .din(din), .nMREQ(nMREQ), .nWR(nWR),
        .m128(m128), .page_ram(page_ram), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .fifo_level(fifo_level), .ovf(ovf)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) begin
            bram[ram_addr] <= ram_din;
            wcnt <= wcnt + 1;
        end
        ram_dout <= bram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // with spam set, ce_7mn toggles every cycle so the slot machine never reaches DRAIN
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (spam) ce_7mn = ~ce_7mn;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        din = d;
        nMREQ = 1'b0;
        nWR = 1'b0;
        repeat (3) tick();
        nMREQ = 1'b1;
        nWR = 1'b1;
        tick();
    endtask

    task automatic fetch(input logic [14:0] a, output logic [7:0] d);
        vram_addr = a;
        ce_7mn = 1'b1;
        tick();
        ce_7mn = 1'b0;
        check("vread_we", ram_we, 0);
        tick();
        check("vcapt_we", ram_we, 0);
        tick();
        d = vram_dout;
    endtask

    task automatic unspam();
        while (ce_7mn !== 1'b1) tick();
        spam = 1'b0;
        ce_7mn = 1'b0;
        tick();
    endtask

    function automatic int scr_index(input logic [15:0] a, input logic m, input logic [2:0] p);
        if (a[15:14] == 2'b01) return int'(a[13:0]);
        if (a[15:14] == 2'b11 && m && p == 3'd5) return int'(a[13:0]);
        if (a[15:14] == 2'b11 && m && p == 3'd7) return 16384 + int'(a[13:0]);
        return -1;
    endfunction

    initial begin
        logic [7:0] d, exp_d;
        logic [14:0] fa;
        logic [13:0] off;
        int base, ph, kind, idx;
        repeat (3) tick();
        check("rst_dout", vram_dout, 0);
        check("rst_raddr", ram_addr, 0);
        check("rst_rdin", ram_din, 0);
        check("rst_we", ram_we, 0);
        check("rst_lvl", fifo_level, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;
        tick();
        cpu_wr(16'h5234, 8'hA5);
        cpu_wr(16'h4100, 8'h99);
        repeat (2) tick();
        vram_addr = 15'h1234;
        ce_7mn = 1'b1;
        tick();
        ce_7mn = 1'b0;
        check("fetch_we_vread", ram_we, 0);
        tick();
        check("fetch_we_vcapt", ram_we, 0);
        check("fetch_early", vram_dout, 0);
        tick();
        check("fetch_a5", vram_dout, 8'hA5);

        base = wcnt;
        addr = 16'h4001;
        din = 8'h3C;
        nMREQ = 1'b0;
        nWR = 1'b0;
        tick();
        check("push_lvl", fifo_level, 1);
        tick();
        check("commit_we", ram_we, 1);
        check("commit_addr", ram_addr, 15'h0001);
        check("commit_din", ram_din, 8'h3C);
        tick();
        nMREQ = 1'b1;
        nWR = 1'b1;
        tick();
        m128 = 1'b1;
        page_ram = 3'd7;
        cpu_wr(16'hC002, 8'h77);
        page_ram = 3'd0;
        cpu_wr(16'hC003, 8'h11);
        cpu_wr(16'h8000, 8'h22);
        m128 = 1'b0;
        repeat (4) tick();
        check("dec_count", wcnt - base, 2);
        check("dec_b5", bram[15'h0001], 8'h3C);
        check("dec_b7", bram[15'h4002], 8'h77);

        vram_addr = 15'h0100;
        ce_7mn = 1'b1;
        spam = 1'b1;
        cpu_wr(16'h4100, 8'h10);
        cpu_wr(16'h4100, 8'h20);
        repeat (2) tick();
        check("fwd_lvl", fifo_level, 2);
        unspam();
        check("fwd_ram_old", bram[15'h0100], 8'h99);
        fetch(15'h0100, d);
        check("fwd_data", d, 8'h20);
        repeat (6) tick();
        check("fwd_commit", bram[15'h0100], 8'h20);

        vram_addr = 15'h1234;
        ce_7mn = 1'b1;
        spam = 1'b1;
        for (int i = 0; i < 4; i++) cpu_wr(16'h4300 + 16'(i), 8'h50 + 8'(i));
        check("ovf_pre", ovf, 0);
        check("ovf_lvl4", fifo_level, 4);
        cpu_wr(16'h4304, 8'h54);
        check("ovf_set", ovf, 1);
        check("ovf_lvl_full", fifo_level, 4);
        unspam();
        repeat (10) tick();
        for (int i = 0; i < 4; i++) check("ovf_kept", bram[15'h0300 + 15'(i)], 8'h50 + 8'(i));
        check("ovf_dropped", bram[15'h0304], 0);
        check("ovf_sticky", ovf, 1);
        check("ovf_drained", fifo_level, 0);

        ce_7mn = 1'b1;
        spam = 1'b1;
        for (int i = 0; i < 3; i++) cpu_wr(16'h4400 + 16'(i), 8'h60 + 8'(i));
        check("rst_q3", fifo_level, 3);
        base = wcnt;
        reset = 1'b1;
        spam = 1'b0;
        ce_7mn = 1'b0;
        tick();
        check("rstm_lvl", fifo_level, 0);
        check("rstm_we", ram_we, 0);
        check("rstm_dout", vram_dout, 0);
        check("rstm_ovf", ovf, 0);
        reset = 1'b0;
        repeat (10) tick();
        check("rstm_nowrite", wcnt - base, 0);
        for (int i = 0; i < 3; i++) check("rstm_ram", bram[15'h0400 + 15'(i)], 0);

        for (int s = 0; s < 1250; s++) begin
            fa = {1'($urandom_range(0, 1)), 14'h2000 + 14'($urandom_range(0, 15))};
            exp_d = ref_mem[fa];
            fetch(fa, d);
            check("soak_fetch", d, exp_d);
            if ($urandom_range(0, 3) != 0) begin
                ph = $urandom_range(5, 7);
                repeat (ph - 3) tick();
                kind = $urandom_range(0, 5);
                off = 14'h2000 + 14'($urandom_range(0, 15));
                addr = {(kind == 0) ? 2'b01 : (kind <= 3) ? 2'b11 : (kind == 4) ? 2'b00 : 2'b10, off};
                m128 = (kind == 1 || kind == 2) ? 1'b1 : (kind == 3) ? 1'b0 : 1'($urandom_range(0, 1));
                page_ram = (kind == 1) ? 3'd5 : (kind == 2 || kind == 3) ? 3'd7 : 3'($urandom_range(0, 7));
                din = 8'($urandom);
                nMREQ = 1'b0;
                nWR = 1'b0;
                tick();
                idx = scr_index(addr, m128, page_ram);
                if (idx >= 0) ref_mem[idx] = din;
                nMREQ = 1'b1;
                nWR = 1'b1;
                repeat (7 - ph) tick();
            end else begin
                repeat (5) tick();
            end
        end
        repeat (10) tick();
        for (int b = 0; b < 2; b++)
            for (int o = 0; o < 16; o++) begin
                idx = b * 16384 + 16'h2000 + o;
                check("soak_ram", bram[idx], ref_mem[idx]);
            end
        check("soak_ovf", ovf, 0);
        check("soak_lvl", fifo_level, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
